fu_issue_arbiter: RTL and testbench

Round-robin issue arbiter that shares one functional unit (e.g. `fu_arith`) among `NUM_REQ` issue-queue requesters. It sits between the issue queues and the FU's `fu_if` control inputs. Each cycle it grants at most one ready requester and captures that requester's payload in a single issue-slot register. It holds the slot until the FU accepts it via `fu_ready`, and it supports flush and stall accounting.

---
 rtl/fu_issue_arbiter_if.sv | 42 ++++
 rtl/fu_issue_arbiter.sv | 116 +++++++++++
 tb/tb_fu_issue_arbiter.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/fu_issue_arbiter_if.sv
// Issue-side bundle between the issue queues, the round-robin issue arbiter
// and the functional unit's control inputs.
interface fu_issue_arbiter_if #(
  parameter int NUM_REQ      = 4,
  parameter int INST_ID_BITS = 6,
  parameter int PRN_BITS     = 6,
  parameter int MAX_OPERANDS = 3
);
  // Handshake: requester i hands off when req_valid[i] && req_grant[i] in the same
  // cycle; the slot hands off to the FU when inst_valid && fu_ready in the same cycle.
  // A valid is never withdrawn by the arbiter until that accept; fu_ready must not
  // depend combinationally on inst_valid or req_grant.
  logic [NUM_REQ-1:0]                                  req_valid;
  logic [NUM_REQ-1:0][INST_ID_BITS-1:0]                req_inst_id;
  logic [NUM_REQ-1:0][31:0]                            req_inst;
  logic [NUM_REQ-1:0][MAX_OPERANDS-1:0][63:0]          req_op;
  logic [NUM_REQ-1:0][MAX_OPERANDS-1:0][PRN_BITS-1:0]  req_out_prn;
  logic [NUM_REQ-1:0][63:0]                            req_pc;
  logic [NUM_REQ-1:0]                                  req_grant;

  logic                                  flush;
  logic                                  fu_ready;
  logic                                  inst_valid;
  logic [INST_ID_BITS-1:0]               inst_id;
  logic [31:0]                           inst;
  logic [MAX_OPERANDS-1:0][63:0]         op;
  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0] out_prn;
  logic [63:0]                           pc;
  logic [15:0]                           stall_cnt;

  modport master (
    input  req_valid, req_inst_id, req_inst, req_op, req_out_prn, req_pc,
    input  flush, fu_ready,
    output req_grant, inst_valid, inst_id, inst, op, out_prn, pc, stall_cnt
  );

  modport slave (
    output req_valid, req_inst_id, req_inst, req_op, req_out_prn, req_pc,
    output flush, fu_ready,
    input  req_grant, inst_valid, inst_id, inst, op, out_prn, pc, stall_cnt
  );
endinterface

// File: rtl/fu_issue_arbiter.sv
// Round-robin arbiter sharing one functional unit among NUM_REQ issue queues,
// with a single issue-slot register, flush and a saturating stall counter.
module fu_issue_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int INST_ID_BITS = 6,
  parameter int PRN_BITS     = 6,
  parameter int MAX_OPERANDS = 3,
  localparam int PTR_W       = $clog2(NUM_REQ)
) (
  input  logic                clk,
  input  logic                rst,
  fu_issue_arbiter_if.master  bus,
  output logic                o_dbg_full,
  output logic [PTR_W-1:0]    o_dbg_rr_ptr
);

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_t;

  state_t                                r_state;
  logic                                  r_inst_valid;
  logic [PTR_W-1:0]                      r_rr_ptr;
  logic [INST_ID_BITS-1:0]               r_inst_id;
  logic [31:0]                           r_inst;
  logic [MAX_OPERANDS-1:0][63:0]         r_op;
  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0] r_out_prn;
  logic [63:0]                           r_pc;
  logic [15:0]                           r_stall_cnt;

  logic                                  w_accept;
  logic                                  w_can_load;
  logic                                  w_grant_any;
  logic [PTR_W-1:0]                      w_grant_idx;
  logic [PTR_W-1:0]                      w_idx;
  logic [PTR_W-1:0]                      w_next_ptr;
  logic [NUM_REQ-1:0]                    w_grant;
  logic                                  w_stall;

  assign w_accept = (r_state == S_FULL) && bus.fu_ready;
  // Reset gates the grant so requesters never retire an entry while the slot is held in reset.
  assign w_can_load = rst && !bus.flush && ((r_state == S_EMPTY) || w_accept);
  assign w_stall = (r_state == S_FULL) && !bus.fu_ready && !bus.flush;

  always_comb begin
    w_grant     = '0;
    w_grant_idx = '0;
    w_grant_any = 1'b0;
    w_idx       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = PTR_W'((32'(r_rr_ptr) + 32'(k)) % 32'(NUM_REQ));
      if (w_can_load && !w_grant_any && bus.req_valid[w_idx]) begin
        w_grant_any = 1'b1;
        w_grant_idx = w_idx;
      end
    end
    if (w_grant_any) begin
      w_grant[w_grant_idx] = 1'b1;
    end
  end

  assign w_next_ptr = (w_grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : w_grant_idx + PTR_W'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_EMPTY;
      r_inst_valid <= 1'b0;
      r_rr_ptr     <= '0;
      r_inst_id    <= '0;
      r_inst       <= '0;
      r_op         <= '0;
      r_out_prn    <= '0;
      r_pc         <= '0;
      r_stall_cnt  <= '0;
    end else begin
      // Flush wins over a simultaneous accept and suppresses any grant.
      if (bus.flush) begin
        r_state      <= S_EMPTY;
        r_inst_valid <= 1'b0;
      end else if (w_grant_any) begin
        r_state      <= S_FULL;
        r_inst_valid <= 1'b1;
      end else if (w_accept) begin
        r_state      <= S_EMPTY;
        r_inst_valid <= 1'b0;
      end

      if (w_grant_any) begin
        r_rr_ptr  <= w_next_ptr;
        r_inst_id <= bus.req_inst_id[w_grant_idx];
        r_inst    <= bus.req_inst[w_grant_idx];
        r_op      <= bus.req_op[w_grant_idx];
        r_out_prn <= bus.req_out_prn[w_grant_idx];
        r_pc      <= bus.req_pc[w_grant_idx];
      end

      if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
        r_stall_cnt <= r_stall_cnt + 16'd1;
      end
    end
  end

  assign bus.req_grant  = w_grant;
  assign bus.inst_valid = r_inst_valid;
  assign bus.inst_id    = r_inst_id;
  assign bus.inst       = r_inst;
  assign bus.op         = r_op;
  assign bus.out_prn    = r_out_prn;
  assign bus.pc         = r_pc;
  assign bus.stall_cnt  = r_stall_cnt;

  assign o_dbg_full   = (r_state == S_FULL);
  assign o_dbg_rr_ptr = r_rr_ptr;

endmodule

// File: tb/tb_fu_issue_arbiter.sv
// Bench for fu_issue_arbiter: directed phases plus random traffic, checked by a
// queue-based scoreboard fed from a rotating-priority reference model.
module tb_fu_issue_arbiter;
  localparam int NR  = 4;
  localparam int IDB = 6;
  localparam int PRB = 6;
  localparam int NOP = 3;
  localparam int W   = IDB + 32 + NOP * 64 + NOP * PRB + 64;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fu_issue_arbiter_if #(.NUM_REQ(NR), .INST_ID_BITS(IDB), .PRN_BITS(PRB), .MAX_OPERANDS(NOP)) bus ();
  logic       dbg_full;
  logic [1:0] dbg_rr;

  fu_issue_arbiter #(.NUM_REQ(NR), .INST_ID_BITS(IDB), .PRN_BITS(PRB), .MAX_OPERANDS(NOP)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .o_dbg_full   (dbg_full),
    .o_dbg_rr_ptr (dbg_rr)
  );

  // Scoreboard state
  logic [W-1:0]  exp_q[$];
  logic [NR-1:0] exp_grant;
  logic [W-1:0]  pend;
  bit            pend_v;
  int            model_rr;
  int            exp_rr;
  logic [15:0]   exp_stall;
  bit            mon_en;
  bit            mon_full;
  int            total = 0;
  int            bad   = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] pack(input logic [IDB-1:0] id, input logic [31:0] ins,
                                        input logic [NOP-1:0][63:0] op,
                                        input logic [NOP-1:0][PRB-1:0] prn, input logic [63:0] pc);
    return {id, ins, op, prn, pc};
  endfunction

  // Reference: first valid requester scanning upward from the pointer, modulo NR.
  function automatic int model_pick(input logic [NR-1:0] v, input int ptr);
    for (int k = 0; k < NR; k++) begin
      if (v[(ptr + k) % NR]) return (ptr + k) % NR;
    end
    return -1;
  endfunction

  task automatic drive_cycle(input logic [NR-1:0] v, input bit rdy, input bit fl);
    int g;
    bit full;
    bus.req_valid = v;
    bus.fu_ready  = rdy;
    bus.flush     = fl;
    for (int i = 0; i < NR; i++) begin
      bus.req_inst_id[i] = IDB'($urandom);
      bus.req_inst[i]    = $urandom;
      bus.req_pc[i]      = {$urandom, $urandom};
      for (int j = 0; j < NOP; j++) begin
        bus.req_op[i][j]      = {$urandom, $urandom};
        bus.req_out_prn[i][j] = PRB'($urandom);
      end
    end
    full      = (exp_q.size() != 0);
    exp_rr    = model_rr;
    exp_grant = '0;
    pend_v    = 1'b0;
    if (!fl && (!full || rdy)) begin
      g = model_pick(v, model_rr);
      if (g >= 0) begin
        exp_grant[g] = 1'b1;
        pend   = pack(bus.req_inst_id[g], bus.req_inst[g], bus.req_op[g], bus.req_out_prn[g], bus.req_pc[g]);
        pend_v = 1'b1;
        model_rr = (g + 1) % NR;
      end
    end
    @(posedge clk);
    #1;
    if (pend_v) exp_q.push_back(pend);
  endtask

  // Monitor: compares every cycle mid-period, pops the slot on accept or flush.
  always @(negedge clk) begin
    if (mon_en) begin
      mon_full = (exp_q.size() != 0);
      check("req_grant", W'(bus.req_grant), W'(exp_grant));
      check("inst_valid", W'(bus.inst_valid), W'(mon_full));
      check("dbg_full", W'(dbg_full), W'(mon_full));
      check("rr_ptr", W'(dbg_rr), W'(exp_rr));
      check("stall_cnt", W'(bus.stall_cnt), W'(exp_stall));
      if (mon_full && bus.inst_valid) begin
        check("payload", pack(bus.inst_id, bus.inst, bus.op, bus.out_prn, bus.pc), exp_q[0]);
      end
      if (mon_full && !bus.fu_ready && !bus.flush && exp_stall != 16'hFFFF) exp_stall = exp_stall + 16'd1;
      if (mon_full && (bus.fu_ready || bus.flush)) void'(exp_q.pop_front());
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.req_valid   = '1;
    bus.fu_ready    = 1'b1;
    bus.flush       = 1'b0;
    bus.req_inst_id = '0;
    bus.req_inst    = '0;
    bus.req_op      = '0;
    bus.req_out_prn = '0;
    bus.req_pc      = '0;
    exp_stall = '0;
    model_rr  = 0;
    exp_rr    = 0;
    exp_grant = '0;
    mon_en    = 1'b0;

    // Reset held with every requester valid
    repeat (3) @(posedge clk);
    #1;
    check("reset_grant", W'(bus.req_grant), '0);
    check("reset_inst_valid", W'(bus.inst_valid), '0);
    check("reset_stall_cnt", W'(bus.stall_cnt), '0);
    check("reset_payload", pack(bus.inst_id, bus.inst, bus.op, bus.out_prn, bus.pc), '0);
    check("reset_rr_ptr", W'(dbg_rr), '0);
    rst    = 1'b1;
    mon_en = 1'b1;

    // Round-robin fairness: all valid, FU always ready
    for (int c = 0; c < 8; c++) drive_cycle(4'b1111, 1'b1, 1'b0);

    // Backpressure: three stalled cycles, then accept with a new grant
    for (int c = 0; c < 3; c++) drive_cycle(4'b1111, 1'b0, 1'b0);
    drive_cycle(4'b1111, 1'b1, 1'b0);

    // Sparse requests and pointer wrap
    drive_cycle(4'b0100, 1'b1, 1'b0);
    drive_cycle(4'b0010, 1'b1, 1'b0);
    drive_cycle(4'b1000, 1'b1, 1'b0);

    // Flush together with accept and a pending request, then the grant resumes
    drive_cycle(4'b0100, 1'b1, 1'b1);
    drive_cycle(4'b0100, 1'b1, 1'b0);
    drive_cycle(4'b0000, 1'b0, 1'b0);

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      drive_cycle(4'($urandom), $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0);
    end

    // Saturation of the stall counter
    drive_cycle(4'b1111, 1'b1, 1'b0);
    for (int c = 0; c < 65540; c++) drive_cycle(4'($urandom), 1'b0, 1'b0);
    check("stall_saturated", W'(bus.stall_cnt), W'(16'hFFFF));
    drive_cycle(4'b0000, 1'b0, 1'b0);
    check("stall_no_wrap", W'(bus.stall_cnt), W'(16'hFFFF));

    // Drain
    drive_cycle(4'b0000, 1'b1, 1'b0);
    drive_cycle(4'b0000, 1'b1, 1'b0);
    @(negedge clk);
    #1;
    mon_en = 1'b0;
    check("drained_inst_valid", W'(bus.inst_valid), '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
